// File: rtl/compressor.sv
// Single-channel audio dynamics compressor.
// Peak envelope follower -> gain from a restoring divider -> gain and makeup
// multiplies -> saturated output. One sample in flight at a time.
module compressor #(
  parameter int bits_per_level = 12,
  parameter int ATTACK_SHIFT   = 0,
  parameter int RELEASE_SHIFT  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [15:0] in_signal,
  input  logic [15:0]        threshold,
  input  logic signed [15:0] makeup,
  output logic               out_valid,
  output logic signed [15:0] out_signal
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] ENV  = 3'd1;
  localparam logic [2:0] DIV  = 3'd2;
  localparam logic [2:0] MUL  = 3'd3;
  localparam logic [2:0] OUT  = 3'd4;

  // Gain carries one integer bit so that unity (1 << bits_per_level) fits.
  localparam int GW = bits_per_level + 1;
  localparam logic [GW-1:0] UNITY = {1'b1, {bits_per_level{1'b0}}};
  localparam int CW = (bits_per_level > 1) ? $clog2(bits_per_level) : 1;
  localparam logic [CW-1:0] LAST = CW'(bits_per_level - 1);

  // Captured sample; threshold is stored already clamped to 0..32767.
  typedef struct packed {
    logic [15:0] x;
    logic [15:0] thr;
    logic [15:0] mk;
  } sample_t;

  logic [2:0]    state;
  sample_t       smp;
  logic [15:0]   env;
  logic [GW-1:0] g;
  logic [15:0]   rem;
  logic [CW-1:0] cnt;

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == OUT)  && !rst;

  // Envelope step: magnitude with -32768 pinned to 32767, then fast attack /
  // slow release toward it. env cannot pass 32767 since a never does.
  logic [15:0] a, env_nx, d_up, d_dn;
  always_comb begin
    if (smp.x == 16'h8000)  a = 16'h7fff;
    else if (smp.x[15])     a = 16'(-smp.x);
    else                    a = smp.x;
    d_up = a - env;
    d_dn = env - a;
    if (a > env) env_nx = env + (d_up >> ATTACK_SHIFT);
    else         env_nx = env - (d_dn >> RELEASE_SHIFT);
  end

  // One restoring-division step: remainder stays below env, so the shifted
  // remainder fits 17 bits and the quotient never reaches unity.
  logic [16:0] rem_sh, rem_diff;
  logic        q_bit;
  always_comb begin
    rem_sh   = {rem, 1'b0};
    rem_diff = rem_sh - {1'b0, env};
    q_bit    = (rem_sh >= {1'b0, env});
  end

  // Gain and makeup multiplies with floor (arithmetic) shifts, then saturate.
  logic signed [31:0] x32, g32, m32, p, y;
  logic [15:0]        y_sat;
  always_comb begin
    x32 = {{16{smp.x[15]}}, smp.x};
    g32 = {{(32-GW){1'b0}}, g};
    m32 = {{16{smp.mk[15]}}, smp.mk};
    p   = (x32 * g32) >>> bits_per_level;
    y   = (p * m32) >>> bits_per_level;
    if (y > 32'sd32767)       y_sat = 16'h7fff;
    else if (y < -32'sd32768) y_sat = 16'h8000;
    else                      y_sat = y[15:0];
  end

  // Sequencer: IDLE -> ENV -> (DIV x bits_per_level) -> MUL -> OUT -> IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      smp        <= '0;
      env        <= '0;
      g          <= '0;
      rem        <= '0;
      cnt        <= '0;
      out_signal <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          smp.x   <= in_signal;
          smp.thr <= threshold[15] ? 16'h7fff : threshold;
          smp.mk  <= makeup;
          state   <= ENV;
        end
        ENV: begin
          env <= env_nx;
          rem <= smp.thr;
          cnt <= '0;
          if (env_nx <= smp.thr) begin
            g     <= UNITY;
            state <= MUL;
          end else begin
            g     <= '0;
            state <= DIV;
          end
        end
        DIV: begin
          if (q_bit) rem <= rem_diff[15:0];
          else       rem <= rem_sh[15:0];
          g   <= {g[GW-2:0], q_bit};
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= MUL;
        end
        MUL: begin
          out_signal <= y_sat;
          state      <= OUT;
        end
        OUT:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_compressor.sv
// Directed bench for compressor: table of samples applied in order (the
// envelope carries between rows), plus reset and mid-division reset sequences.
module tb_compressor;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [15:0] in_signal = '0;
  logic [15:0]        threshold = '0;
  logic signed [15:0] makeup = '0;
  logic               out_valid;
  logic signed [15:0] out_signal;

  compressor dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_signal(in_signal), .threshold(threshold), .makeup(makeup),
    .out_valid(out_valid), .out_signal(out_signal)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  typedef struct {
    int x;
    int thr;
    int mk;
    int exp_y;
    int exp_lat;
  } vec_t;

  // Offer one sample, then watch 20 cycles after acceptance for the pulse.
  task automatic run_vec(input string nm, input vec_t v);
    int wait_cyc;
    int seen_at;
    int pulses;
    int y_got;
    int rdy_after;
    @(negedge clk);
    in_valid  = 1'b1;
    in_signal = 16'(v.x);
    threshold = 16'(v.thr);
    makeup    = 16'(v.mk);
    wait_cyc  = 0;
    while (!in_ready && wait_cyc < 100) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (!in_ready) begin
      chk({nm, " ready_timeout"}, 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    // Inputs must have been captured at the accept edge; scramble them.
    in_valid  = 1'b0;
    in_signal = 16'($urandom);
    threshold = 16'($urandom);
    makeup    = 16'($urandom);
    seen_at = 0; pulses = 0; y_got = 0; rdy_after = 0;
    for (int n = 1; n <= 20; n++) begin
      if (out_valid) begin
        pulses++;
        if (seen_at == 0) begin
          seen_at = n;
          y_got   = int'(out_signal);
        end
      end
      if (n == v.exp_lat + 1) rdy_after = int'(in_ready);
      @(posedge clk);
      #1;
    end
    chk({nm, " latency"}, seen_at, v.exp_lat);
    chk({nm, " out_signal"}, y_got, v.exp_y);
    chk({nm, " pulse_count"}, pulses, 1);
    chk({nm, " ready_after"}, rdy_after, 1);
  endtask

  vec_t vt[9];

  initial begin
    // x, threshold, makeup, expected y, expected out_valid cycle
    vt[0] = '{1000, 8000, 4096, 1000, 3};       // env 1000, no division
    vt[1] = '{16000, 8000, 4096, 8000, 15};     // env 16000, g 2048
    vt[2] = '{0, 8000, 4096, 0, 15};            // env 15938, g 2055
    vt[3] = '{-32768, 32767, 8192, -32768, 3};  // env 32767, y -65536 saturates
    vt[4] = '{20000, 40000, 4096, 20000, 3};    // threshold clamps; env 32718
    vt[5] = '{100, 0, 4096, 0, 15};             // threshold 0 -> g 0; env 32591
    vt[6] = '{-3000, 32767, 2048, -1500, 3};    // env 32476
    vt[7] = '{-3001, 32767, 2048, -1501, 3};    // floor of -1500.5; env 32361
    vt[8] = '{-16001, 16000, 4096, -7927, 15};  // env 32298, g 2029, p floor

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst in_ready", int'(in_ready), 0);
    chk("rst out_valid", int'(out_valid), 0);
    chk("rst out_signal", int'(out_signal), 0);
    rst = 1'b0;
    #1;
    chk("release in_ready", int'(in_ready), 1);

    for (int i = 0; i < 9; i++)
      run_vec($sformatf("vec%0d", i), vt[i]);

    // Positive saturation: env 32767, p 32767, y 262128
    run_vec("possat", '{32767, 32767, 32767, 32767, 3});

    // Reset during division: env 0 -> 16000, reset lands at T+8.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    begin
      int pulses;
      int wait_cyc;
      pulses = 0;
      @(negedge clk);
      in_valid  = 1'b1;
      in_signal = 16'sd16000;
      threshold = 16'd8000;
      makeup    = 16'sd4096;
      wait_cyc  = 0;
      while (!in_ready && wait_cyc < 100) begin
        @(negedge clk);
        wait_cyc++;
      end
      chk("middiv accepted", int'(in_ready), 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      for (int n = 1; n <= 20; n++) begin
        if (out_valid) pulses++;
        if (n == 8) rst = 1'b1;
        if (n == 9) begin
          chk("middiv rst in_ready", int'(in_ready), 0);
          chk("middiv rst out_signal", int'(out_signal), 0);
        end
        if (n == 10) rst = 1'b0;
        if (n == 11) chk("middiv release in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
      end
      chk("middiv pulses", pulses, 0);
    end
    // Env must have restarted from 0, else this would take the division path.
    run_vec("after_middiv", '{1000, 8000, 4096, 1000, 3});

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end

endmodule

// File: doc/compressor.md
COMPRESSOR -- requirements
Module: compressor

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset, with the clock and reset ports named clk and rst.
REQ-002 Parameter bits_per_level, default 12, SHALL set the fraction bits of all gain values (1.0 = 4096).
REQ-003 Parameter ATTACK_SHIFT, default 0, SHALL set the envelope rise shift.
REQ-004 Parameter RELEASE_SHIFT, default 8, SHALL set the envelope decay shift.
REQ-005 Port clk, input, 1 bit: rising-edge clock for all state.
REQ-006 Port rst, input, 1 bit: synchronous active-high reset.
REQ-007 Port in_valid, input, 1 bit: in_signal, threshold and makeup are valid.
REQ-008 Port in_ready, output, 1 bit: the module can accept a sample.
REQ-009 Port in_signal, input, 16 bits signed: audio sample.
REQ-010 Port threshold, input, 16 bits unsigned: compression knee, 0..32767; values above 32767 SHALL be treated as 32767.
REQ-011 Port makeup, input, 16 bits signed: post-gain, Q4.12.
REQ-012 Port out_valid, output, 1 bit: one-cycle pulse that qualifies out_signal.
REQ-013 Port out_signal, output, 16 bits signed: compressed sample, held between pulses.

Function
REQ-014 The FSM SHALL have the states IDLE, ENV, DIV, MUL and OUT, and in_ready SHALL equal (state == IDLE) && !rst.
REQ-015 A sample is accepted when in_valid and in_ready are both high in cycle T; in_signal, threshold and makeup SHALL be registered in that cycle and ignored afterwards.
REQ-016 In ENV (T+1), the magnitude a SHALL be |in_signal|, with |-32768| saturating to 32767.
REQ-017 In ENV (T+1), the envelope update SHALL be: if a > env, env += (a - env) >> ATTACK_SHIFT; otherwise env -= (env - a) >> RELEASE_SHIFT.
REQ-018 If the new env <= threshold, gain g SHALL be 4096 and the next state SHALL be MUL; otherwise the next state SHALL be DIV.
REQ-019 DIV SHALL compute g = floor((threshold << bits_per_level) / env) with a restoring divider producing one quotient bit per cycle.
REQ-020 DIV SHALL produce 12 quotient bits over cycles T+2..T+13; g < 4096 always.
REQ-021 MUL SHALL compute p = (x * g) >>> bits_per_level and then y = (p * makeup) >>> bits_per_level, using 32-bit signed intermediates.
REQ-022 The shifts in MUL SHALL be arithmetic and SHALL truncate toward negative infinity.
REQ-023 y SHALL saturate to [-32768, 32767] before out_signal is registered.
REQ-024 In OUT, out_signal SHALL be updated and out_valid SHALL be high for exactly one cycle, with no backpressure; the next state SHALL be IDLE.
REQ-025 Latency without division SHALL be: MUL at T+2, out_valid at T+3, in_ready high again at T+4.
REQ-026 Latency with division SHALL be: MUL at T+14, out_valid at T+15, in_ready high again at T+16.
REQ-027 in_valid while in_ready is low SHALL be ignored, with no queuing; in_valid held high SHALL be accepted at the next IDLE cycle.
REQ-028 threshold = 0 with env > 0 SHALL give g = 0 and out_signal = 0; env = 0 SHALL always take the no-division path.
REQ-029 env SHALL be 16-bit unsigned and SHALL never exceed 32767.

Reset
REQ-030 While rst is high, the state SHALL be IDLE, env SHALL be 0, out_signal SHALL be 0, out_valid SHALL be 0 and in_ready SHALL be 0.
REQ-031 in_ready SHALL be 1 in the first cycle after rst is deasserted.
REQ-032 Reset asserted in any state, including mid-DIV, SHALL abort the in-flight sample with no out_valid and SHALL clear the divider and env.
REQ-033 Reset SHALL take priority over a simultaneous in_valid.

Verification
REQ-034 Reset case: after rst, out_valid = 0, out_signal = 0 and in_ready = 1 on the first cycle after release.
REQ-035 No-division case: in_signal = 1000, threshold = 8000, makeup = 4096 -> out_valid at T+3 with out_signal = 1000.
REQ-036 Division case: in_signal = 16000, threshold = 8000, makeup = 4096 from env = 0 -> env = 16000, g = 2048, out_valid at T+15 with out_signal = 8000.
REQ-037 Release case: immediately after REQ-036, in_signal = 0 with the same threshold -> env = 15938, g = 2055, out_valid at T+15 with out_signal = 0.
REQ-038 Saturation case: in_signal = -32768, threshold = 32767, makeup = 8192 -> no division, y = -65536 saturated, out_signal = -32768 at T+3.
REQ-039 Mid-DIV reset case: assert rst at T+8 of the REQ-036 stimulus -> no out_valid; then the REQ-035 stimulus -> out_signal = 1000 at T+3 (env restarted from 0).
